// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state encoding for the burst master.
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned PAGE_BYTES = 4096;

  // AXI responses are ordered by severity, so "worst" is a plain max.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI burst master: one command in, one INCR burst out, one done pulse.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int unsigned DW  = 128,
  parameter int unsigned AW  = 32,
  parameter int unsigned IDW = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [IDW-1:0]    cmd_id,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  input  logic [DW-1:0]     wdat_data,
  input  logic [DW/8-1:0]   wdat_strb,
  output logic              rdat_valid,
  input  logic              rdat_ready,
  output logic [DW-1:0]     rdat_data,
  output logic              rdat_last,
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic              mem_aw_valid,
  input  logic              mem_aw_ready,
  output logic [IDW-1:0]    mem_aw_id,
  output logic [AW-1:0]     mem_aw_addr,
  output logic [7:0]        mem_aw_len,
  output logic [2:0]        mem_aw_size,
  output logic [1:0]        mem_aw_burst,
  output logic              mem_ar_valid,
  input  logic              mem_ar_ready,
  output logic [IDW-1:0]    mem_ar_id,
  output logic [AW-1:0]     mem_ar_addr,
  output logic [7:0]        mem_ar_len,
  output logic [2:0]        mem_ar_size,
  output logic [1:0]        mem_ar_burst,
  output logic              mem_w_valid,
  input  logic              mem_w_ready,
  output logic [DW-1:0]     mem_w_data,
  output logic [DW/8-1:0]   mem_w_strb,
  output logic              mem_w_last,
  input  logic              mem_b_valid,
  output logic              mem_b_ready,
  input  logic [IDW-1:0]    mem_b_id,
  input  logic [1:0]        mem_b_resp,
  input  logic              mem_r_valid,
  output logic              mem_r_ready,
  input  logic [IDW-1:0]    mem_r_id,
  input  logic [DW-1:0]     mem_r_data,
  input  logic [1:0]        mem_r_resp,
  input  logic              mem_r_last
);

  localparam int unsigned   SZ       = $clog2(DW / 8);
  localparam logic [AW-1:0] LOW_MASK = AW'((64'd1 << SZ) - 64'd1);

  state_t         state;
  logic [AW-1:0]  addr;
  logic [7:0]     len;
  logic [IDW-1:0] id;
  logic [7:0]     cnt;
  logic [1:0]     resp;
  logic [1:0]     r_acc;
  logic [1:0]     b_acc;
  logic [AW-1:0]  addr_m;
  logic [23:0]    span;
  logic           page_cross;
  logic           last_beat;

  assign addr_m     = cmd_addr & ~LOW_MASK;
  assign span       = 24'(addr_m[11:0]) + ((24'(cmd_len) + 24'd1) << SZ);
  assign page_cross = span > 24'(PAGE_BYTES);
  assign last_beat  = (cnt == 8'd0);

  // RLAST or ID disagreement is a local error but never stalls the stream.
  always_comb begin
    r_acc = resp_max(resp, mem_r_resp);
    if ((mem_r_last != last_beat) || (mem_r_id != id))
      r_acc = resp_max(r_acc, RESP_SLVERR);
    b_acc = resp_max(resp, mem_b_resp);
    if (mem_b_id != id)
      b_acc = resp_max(b_acc, RESP_SLVERR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      addr  <= '0;
      len   <= '0;
      id    <= '0;
      cnt   <= '0;
      resp  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid) begin
          addr <= addr_m;
          len  <= cmd_len;
          id   <= cmd_id;
          cnt  <= cmd_len;
          if (page_cross) begin
            resp  <= RESP_SLVERR;
            state <= ST_DONE;
          end else begin
            resp  <= RESP_OKAY;
            state <= cmd_wr ? ST_AW : ST_AR;
          end
        end
        ST_AR: if (mem_ar_ready) state <= ST_R;
        ST_AW: if (mem_aw_ready) state <= ST_W;
        ST_W: if (wdat_valid && mem_w_ready) begin
          cnt <= cnt - 8'd1;
          if (last_beat) state <= ST_B;
        end
        ST_B: if (mem_b_valid) begin
          resp  <= b_acc;
          state <= ST_DONE;
        end
        ST_R: if (mem_r_valid && rdat_ready) begin
          resp <= r_acc;
          cnt  <= cnt - 8'd1;
          if (last_beat) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state == ST_IDLE);
  assign done_valid   = (state == ST_DONE);
  assign done_resp    = (state == ST_DONE) ? resp : RESP_OKAY;

  assign mem_ar_valid = (state == ST_AR);
  assign mem_ar_id    = id;
  assign mem_ar_addr  = addr;
  assign mem_ar_len   = len;
  assign mem_ar_size  = 3'(SZ);
  assign mem_ar_burst = BURST_INCR;

  assign mem_aw_valid = (state == ST_AW);
  assign mem_aw_id    = id;
  assign mem_aw_addr  = addr;
  assign mem_aw_len   = len;
  assign mem_aw_size  = 3'(SZ);
  assign mem_aw_burst = BURST_INCR;

  assign mem_w_valid  = (state == ST_W) && wdat_valid;
  assign wdat_ready   = (state == ST_W) && mem_w_ready;
  assign mem_w_data   = wdat_data;
  assign mem_w_strb   = wdat_strb;
  assign mem_w_last   = last_beat;

  assign mem_b_ready  = (state == ST_B);

  assign rdat_valid   = (state == ST_R) && mem_r_valid;
  assign mem_r_ready  = (state == ST_R) && rdat_ready;
  assign rdat_data    = mem_r_data;
  assign rdat_last    = last_beat;

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: cycle-stepped slave model, expected beats queued per test.
module tb_axi_burst_master;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int IDW = 4;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            last;
  } beat_t;

  logic clock = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [IDW-1:0] cmd_id;
  logic wdat_valid, wdat_ready;
  logic [DW-1:0] wdat_data;
  logic [DW/8-1:0] wdat_strb;
  logic rdat_valid, rdat_ready, rdat_last;
  logic [DW-1:0] rdat_data;
  logic done_valid;
  logic [1:0] done_resp;
  logic mem_aw_valid, mem_aw_ready, mem_ar_valid, mem_ar_ready;
  logic [IDW-1:0] mem_aw_id, mem_ar_id, mem_b_id, mem_r_id;
  logic [AW-1:0] mem_aw_addr, mem_ar_addr;
  logic [7:0] mem_aw_len, mem_ar_len;
  logic [2:0] mem_aw_size, mem_ar_size;
  logic [1:0] mem_aw_burst, mem_ar_burst;
  logic mem_w_valid, mem_w_ready, mem_w_last;
  logic [DW-1:0] mem_w_data, mem_r_data;
  logic [DW/8-1:0] mem_w_strb;
  logic mem_b_valid, mem_b_ready, mem_r_valid, mem_r_ready, mem_r_last;
  logic [1:0] mem_b_resp, mem_r_resp;

  axi_burst_master #(.DW(DW), .AW(AW), .IDW(IDW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data), .wdat_strb(wdat_strb),
    .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data), .rdat_last(rdat_last),
    .done_valid(done_valid), .done_resp(done_resp),
    .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready), .mem_aw_id(mem_aw_id),
    .mem_aw_addr(mem_aw_addr), .mem_aw_len(mem_aw_len), .mem_aw_size(mem_aw_size),
    .mem_aw_burst(mem_aw_burst),
    .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_id(mem_ar_id),
    .mem_ar_addr(mem_ar_addr), .mem_ar_len(mem_ar_len), .mem_ar_size(mem_ar_size),
    .mem_ar_burst(mem_ar_burst),
    .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready), .mem_w_data(mem_w_data),
    .mem_w_strb(mem_w_strb), .mem_w_last(mem_w_last),
    .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready), .mem_b_id(mem_b_id), .mem_b_resp(mem_b_resp),
    .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_id(mem_r_id),
    .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp), .mem_r_last(mem_r_last)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  beat_t exp_r[$], obs_r[$], exp_w[$], obs_w[$];

  // Slave behaviour knobs
  logic [1:0] k_rresp [16];
  int k_rlast_beat, k_stall_lo, k_stall_hi, k_wgap, k_rst_beat;
  bit k_rid_bad;
  logic [1:0] k_bresp;

  // Observations from the last burst
  int o_ar_cnt, o_aw_cnt, o_b_cnt, o_done_cnt, o_done_lat, o_w_early, o_rready_bad, o_cr_in_done;
  logic o_cr_after;
  logic [1:0] o_done_resp;
  logic [7:0] o_snap;
  logic [AW-1:0] o_ax_addr;
  logic [7:0] o_ax_len;
  logic [2:0] o_ax_size;
  logic [1:0] o_ax_burst;
  logic [IDW-1:0] o_ax_id;

  function automatic logic [DW-1:0] rpat(int i);
    return {32'hD000_0000 + 32'(i), 32'hCAFE_0000 ^ 32'(i), ~32'(i), 32'(i * 7)};
  endfunction

  function automatic logic [DW-1:0] wpat(int i);
    return {32'h5A5A_0000 + 32'(i), 32'(i * 13), 32'hFEED_0000 | 32'(i), ~32'(i * 5)};
  endfunction

  function automatic logic [DW/8-1:0] wstrb(int i);
    return 16'(16'hFFFF >> i);
  endfunction

  task automatic set_defaults(input int len);
    for (int i = 0; i < 16; i++) k_rresp[i] = 2'b00;
    k_rlast_beat = len;
    k_stall_lo = 1000;
    k_stall_hi = -1;
    k_wgap = 0;
    k_rst_beat = -1;
    k_rid_bad = 1'b0;
    k_bresp = 2'b00;
  endtask

  task automatic drive_idle();
    reset = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wdat_valid = 1'b0; wdat_data = '0; wdat_strb = '0; rdat_ready = 1'b0;
    mem_aw_ready = 1'b0; mem_ar_ready = 1'b0; mem_w_ready = 1'b0;
    mem_b_valid = 1'b0; mem_b_id = '0; mem_b_resp = '0;
    mem_r_valid = 1'b0; mem_r_id = '0; mem_r_data = '0; mem_r_resp = '0; mem_r_last = 1'b0;
  endtask

  // Runs one command against a zero-wait slave model, recording what the DUT does.
  task automatic run_burst(input logic wr, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [IDW-1:0] id);
    int t_cmd = 0, t_done = 0, t_abort = 0, r_idx = 0, w_idx = 0, gap = 0;
    bit cmd_sent = 0, ar_done = 0, aw_done = 0, b_sent = 0, aborted = 0;
    obs_r.delete(); obs_w.delete();
    o_ar_cnt = 0; o_aw_cnt = 0; o_b_cnt = 0; o_done_cnt = 0; o_done_lat = -1; o_w_early = 0;
    o_rready_bad = 0; o_cr_in_done = 0; o_cr_after = 1'bx; o_done_resp = 2'bxx; o_snap = 8'hxx;
    for (int t = 0; t < 300; t++) begin
      @(negedge clock);
      if (aborted) begin
        drive_idle();
        wdat_valid = 1'b1; mem_r_valid = 1'b1; mem_b_valid = 1'b1; rdat_ready = 1'b1;
        mem_w_ready = 1'b1; mem_ar_ready = 1'b1; mem_aw_ready = 1'b1;
      end else begin
        cmd_valid = !cmd_sent; cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
        mem_ar_ready = 1'b1; mem_aw_ready = 1'b1; mem_w_ready = 1'b1;
        mem_r_valid = ar_done && (r_idx <= int'(len));
        mem_r_data = rpat(r_idx);
        mem_r_resp = k_rresp[r_idx % 16];
        mem_r_last = (r_idx == k_rlast_beat);
        mem_r_id = k_rid_bad ? ~id : id;
        rdat_ready = !(cmd_sent && (t - t_cmd) >= k_stall_lo && (t - t_cmd) <= k_stall_hi);
        wdat_valid = wr && cmd_sent && (w_idx <= int'(len)) && (gap == 0);
        wdat_data = wpat(w_idx);
        wdat_strb = wstrb(w_idx);
        mem_b_valid = wr && (w_idx > int'(len)) && !b_sent;
        mem_b_resp = k_bresp;
        mem_b_id = id;
        reset = (k_rst_beat >= 0) && (w_idx == k_rst_beat) && aw_done;
      end
      #1;
      if (aborted) begin
        if (t == t_abort + 1)
          o_snap = {mem_ar_valid, mem_aw_valid, mem_w_valid, rdat_valid, done_valid,
                    mem_b_ready, mem_r_ready, cmd_ready};
        if (done_valid) o_done_cnt++;
        if (t >= t_abort + 4) break;
      end else begin
        if (cmd_valid && cmd_ready && !cmd_sent) begin cmd_sent = 1; t_cmd = t; end
        if (mem_w_valid && !aw_done) o_w_early++;
        if (mem_ar_valid && mem_ar_ready) begin
          o_ar_cnt++; ar_done = 1;
          o_ax_addr = mem_ar_addr; o_ax_len = mem_ar_len; o_ax_size = mem_ar_size;
          o_ax_burst = mem_ar_burst; o_ax_id = mem_ar_id;
        end
        if (mem_aw_valid && mem_aw_ready) begin
          o_aw_cnt++; aw_done = 1;
          o_ax_addr = mem_aw_addr; o_ax_len = mem_aw_len; o_ax_size = mem_aw_size;
          o_ax_burst = mem_aw_burst; o_ax_id = mem_aw_id;
        end
        if (cmd_sent && (t - t_cmd) >= k_stall_lo && (t - t_cmd) <= k_stall_hi && mem_r_ready !== 1'b0)
          o_rready_bad++;
        if (rdat_valid && rdat_ready) begin
          obs_r.push_back('{data: rdat_data, strb: '0, last: rdat_last});
          r_idx++;
        end
        if (mem_w_valid && mem_w_ready) begin
          obs_w.push_back('{data: mem_w_data, strb: mem_w_strb, last: mem_w_last});
          w_idx++; gap = k_wgap;
        end else if (gap > 0) gap--;
        if (mem_b_valid && mem_b_ready) begin o_b_cnt++; b_sent = 1; end
        if (done_valid) begin
          o_done_cnt++; o_done_resp = done_resp; o_done_lat = t - t_cmd; t_done = t;
          if (cmd_ready) o_cr_in_done++;
        end
        if (o_done_cnt > 0 && t == t_done + 1) o_cr_after = cmd_ready;
        if (reset) begin aborted = 1; t_abort = t; end
        if (o_done_cnt > 0 && t >= t_done + 2) break;
      end
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1; cmd_valid = 1'b1; wdat_valid = 1'b1; mem_r_valid = 1'b1; mem_b_valid = 1'b1;
    rdat_ready = 1'b1; mem_w_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    vectors++;
    if ({mem_ar_valid, mem_aw_valid, mem_w_valid, rdat_valid, done_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_valids got=%b exp=00000",
               {mem_ar_valid, mem_aw_valid, mem_w_valid, rdat_valid, done_valid});
    end
    vectors++;
    if ({mem_b_ready, mem_r_ready, wdat_ready} !== 3'b0) begin
      miscompares++; $display("FAIL reset_readies got=%b exp=000", {mem_b_ready, mem_r_ready, wdat_ready});
    end
    vectors++;
    if (done_resp !== 2'b00) begin miscompares++; $display("FAIL reset_done_resp got=%b exp=00", done_resp); end
    drive_idle();
    @(negedge clock);
  endtask

  task automatic test_read_burst();
    beat_t e, o;
    set_defaults(3);
    for (int i = 0; i < 4; i++) exp_r.push_back('{data: rpat(i), strb: '0, last: (i == 3)});
    run_burst(1'b0, 32'h100, 8'd3, 4'h5);
    vectors++;
    if (obs_r.size() != 4) begin miscompares++; $display("FAIL rd_beat_count got=%0d exp=4", obs_r.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      e = exp_r.pop_front(); o = obs_r.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rd_beat got=%h exp=%h", o, e); end
    end
    exp_r.delete();
    vectors++;
    if ({o_ax_addr, o_ax_len, o_ax_size, o_ax_burst, o_ax_id} !== {32'h100, 8'd3, 3'd4, 2'b01, 4'h5}) begin
      miscompares++;
      $display("FAIL rd_ar_fields got=%h/%h/%h/%h/%h exp=100/03/4/1/5",
               o_ax_addr, o_ax_len, o_ax_size, o_ax_burst, o_ax_id);
    end
    vectors++;
    if (o_ar_cnt != 1 || o_aw_cnt != 0) begin
      miscompares++; $display("FAIL rd_addr_count got=ar%0d/aw%0d exp=ar1/aw0", o_ar_cnt, o_aw_cnt);
    end
    vectors++;
    if (o_done_cnt != 1 || o_done_resp !== 2'b00) begin
      miscompares++; $display("FAIL rd_done got=%0d/%b exp=1/00", o_done_cnt, o_done_resp);
    end
    vectors++;
    if (o_done_lat != 6) begin miscompares++; $display("FAIL rd_latency got=%0d exp=6", o_done_lat); end
    vectors++;
    if (o_cr_in_done != 0 || o_cr_after !== 1'b1) begin
      miscompares++; $display("FAIL rd_cmd_ready_after got=%0d/%b exp=0/1", o_cr_in_done, o_cr_after);
    end
  endtask

  task automatic test_write_burst();
    beat_t e, o;
    set_defaults(1);
    k_wgap = 2;
    for (int i = 0; i < 2; i++) exp_w.push_back('{data: wpat(i), strb: wstrb(i), last: (i == 1)});
    run_burst(1'b1, 32'h207, 8'd1, 4'hA);
    vectors++;
    if (obs_w.size() != 2) begin miscompares++; $display("FAIL wr_beat_count got=%0d exp=2", obs_w.size()); end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      e = exp_w.pop_front(); o = obs_w.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL wr_beat got=%h exp=%h", o, e); end
    end
    exp_w.delete();
    vectors++;
    if ({o_ax_addr, o_ax_len, o_ax_size, o_ax_burst, o_ax_id} !== {32'h200, 8'd1, 3'd4, 2'b01, 4'hA}) begin
      miscompares++;
      $display("FAIL wr_aw_fields got=%h/%h/%h/%h/%h exp=200/01/4/1/a",
               o_ax_addr, o_ax_len, o_ax_size, o_ax_burst, o_ax_id);
    end
    vectors++;
    if (o_w_early != 0) begin miscompares++; $display("FAIL wr_early_beat got=%0d exp=0", o_w_early); end
    vectors++;
    if (o_b_cnt != 1 || o_aw_cnt != 1 || o_ar_cnt != 0) begin
      miscompares++; $display("FAIL wr_counts got=b%0d/aw%0d/ar%0d exp=b1/aw1/ar0", o_b_cnt, o_aw_cnt, o_ar_cnt);
    end
    vectors++;
    if (o_done_cnt != 1 || o_done_resp !== 2'b00) begin
      miscompares++; $display("FAIL wr_done got=%0d/%b exp=1/00", o_done_cnt, o_done_resp);
    end
  endtask

  task automatic test_page_cross();
    set_defaults(1);
    run_burst(1'b0, 32'hFF0, 8'd1, 4'h1);
    vectors++;
    if (o_ar_cnt != 0 || obs_r.size() != 0) begin
      miscompares++; $display("FAIL xpage_traffic got=ar%0d/r%0d exp=ar0/r0", o_ar_cnt, obs_r.size());
    end
    vectors++;
    if (o_done_cnt != 1 || o_done_resp !== 2'b10) begin
      miscompares++; $display("FAIL xpage_done got=%0d/%b exp=1/10", o_done_cnt, o_done_resp);
    end
    vectors++;
    if (o_done_lat < 1 || o_done_lat > 2) begin
      miscompares++; $display("FAIL xpage_latency got=%0d exp=1..2", o_done_lat);
    end
    set_defaults(1);
    run_burst(1'b0, 32'hFE0, 8'd1, 4'h1);
    vectors++;
    if (o_ar_cnt != 1 || obs_r.size() != 2 || o_done_resp !== 2'b00) begin
      miscompares++;
      $display("FAIL page_edge got=ar%0d/r%0d/%b exp=ar1/r2/00", o_ar_cnt, obs_r.size(), o_done_resp);
    end
  endtask

  task automatic test_resp_errors();
    beat_t e, o;
    set_defaults(2);
    k_rresp[1] = 2'b01;
    k_rlast_beat = 1;
    for (int i = 0; i < 3; i++) exp_r.push_back('{data: rpat(i), strb: '0, last: (i == 2)});
    run_burst(1'b0, 32'h040, 8'd2, 4'h3);
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      e = exp_r.pop_front(); o = obs_r.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL rlast_beat got=%h exp=%h", o, e); end
    end
    vectors++;
    if (exp_r.size() != 0 || obs_r.size() != 0) begin
      miscompares++; $display("FAIL rlast_beat_count left=%0d extra=%0d exp=0/0", exp_r.size(), obs_r.size());
    end
    exp_r.delete();
    vectors++;
    if (o_done_cnt != 1 || o_done_resp !== 2'b10) begin
      miscompares++; $display("FAIL rlast_done got=%0d/%b exp=1/10", o_done_cnt, o_done_resp);
    end
    set_defaults(1);
    k_rresp[1] = 2'b01;
    run_burst(1'b0, 32'h080, 8'd1, 4'h3);
    vectors++;
    if (o_done_resp !== 2'b01) begin miscompares++; $display("FAIL rresp_max got=%b exp=01", o_done_resp); end
    set_defaults(0);
    k_rid_bad = 1'b1;
    run_burst(1'b0, 32'h0C0, 8'd0, 4'h6);
    vectors++;
    if (obs_r.size() != 1 || o_done_cnt != 1 || o_done_resp !== 2'b10) begin
      miscompares++;
      $display("FAIL rid_mismatch got=r%0d/d%0d/%b exp=r1/d1/10", obs_r.size(), o_done_cnt, o_done_resp);
    end
    set_defaults(0);
    k_bresp = 2'b11;
    run_burst(1'b1, 32'h0C0, 8'd0, 4'h6);
    vectors++;
    if (o_done_resp !== 2'b11) begin miscompares++; $display("FAIL bresp got=%b exp=11", o_done_resp); end
  endtask

  task automatic test_backpressure();
    beat_t e, o;
    set_defaults(7);
    k_stall_lo = 4;
    k_stall_hi = 8;
    for (int i = 0; i < 8; i++) exp_r.push_back('{data: rpat(i), strb: '0, last: (i == 7)});
    run_burst(1'b0, 32'h000, 8'd7, 4'h2);
    vectors++;
    if (o_rready_bad != 0) begin miscompares++; $display("FAIL stall_r_ready got=%0d exp=0", o_rready_bad); end
    vectors++;
    if (obs_r.size() != 8) begin miscompares++; $display("FAIL stall_beat_count got=%0d exp=8", obs_r.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      e = exp_r.pop_front(); o = obs_r.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL stall_beat got=%h exp=%h", o, e); end
    end
    exp_r.delete();
    vectors++;
    if (o_done_cnt != 1 || o_done_resp !== 2'b00) begin
      miscompares++; $display("FAIL stall_done got=%0d/%b exp=1/00", o_done_cnt, o_done_resp);
    end
  endtask

  task automatic test_reset_mid_write();
    set_defaults(7);
    k_rst_beat = 1;
    run_burst(1'b1, 32'h400, 8'd7, 4'h9);
    vectors++;
    if (o_snap !== 8'b0000_0001) begin miscompares++; $display("FAIL abort_outputs got=%b exp=00000001", o_snap); end
    vectors++;
    if (o_done_cnt != 0) begin miscompares++; $display("FAIL abort_done got=%0d exp=0", o_done_cnt); end
    set_defaults(0);
    run_burst(1'b0, 32'h500, 8'd0, 4'h4);
    vectors++;
    if (o_done_cnt != 1 || o_done_resp !== 2'b00 || obs_r.size() != 1) begin
      miscompares++;
      $display("FAIL abort_recover got=d%0d/%b/r%0d exp=d1/00/r1", o_done_cnt, o_done_resp, obs_r.size());
    end
  endtask

  task automatic test_back_to_back();
    beat_t o;
    set_defaults(0);
    run_burst(1'b1, 32'h300, 8'd0, 4'h7);
    vectors++;
    o = (obs_w.size() > 0) ? obs_w.pop_front() : '0;
    if (o !== beat_t'{data: wpat(0), strb: wstrb(0), last: 1'b1} || o_done_cnt != 1) begin
      miscompares++; $display("FAIL b2b_write got=%h/d%0d exp=%h/d1", o, o_done_cnt, wpat(0));
    end
    set_defaults(0);
    run_burst(1'b0, 32'h310, 8'd0, 4'h8);
    vectors++;
    o = (obs_r.size() > 0) ? obs_r.pop_front() : '0;
    if (o !== beat_t'{data: rpat(0), strb: '0, last: 1'b1} || o_done_lat != 3) begin
      miscompares++; $display("FAIL b2b_read got=%h/lat%0d exp=%h/lat3", o, o_done_lat, rpat(0));
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_read_burst();
    test_write_burst();
    test_page_cross();
    test_resp_errors();
    test_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
